// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux.
// Grants are bounded by a hold counter and hand over with no idle cycle.
module mux4_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s2,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [1:0]      last;
    logic [CW-1:0]   cnt;
    logic [1:0]      win;
    logic            release_h;

    // First requester at or after last+1, wrapping; last itself is scanned last.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        logic [1:0] idx;
        pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        win       = pick(req, last);
        release_h = !req[last] || (cnt == CW'(HOLD_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            s1    <= 1'b0;
            s2    <= 1'b0;
            busy  <= 1'b0;
            last  <= 2'd3;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        gnt      <= 4'b0001 << win;
                        {s1, s2} <= win;
                        busy     <= 1'b1;
                        last     <= win;
                        cnt      <= CW'(1);
                    end
                end
                GRANT: begin
                    if (!release_h) begin
                        cnt <= cnt + CW'(1);
                    end else if (|req) begin
                        gnt      <= 4'b0001 << win;
                        {s1, s2} <= win;
                        busy     <= 1'b1;
                        last     <= win;
                        cnt      <= CW'(1);
                    end else begin
                        // Select lines keep their value so the mux output stays put.
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: stimulus pushes expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_mux4_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s2;
    logic       busy;

    exp_t  q[$];
    string nq[$];
    int    total;
    int    passed;
    int    failed;

    mux4_arbiter #(.HOLD_MAX(8), .CW(8)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .gnt  (gnt),
        .s1   (s1),
        .s2   (s2),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input logic       r,
        input logic [3:0] rq,
        input logic [3:0] g,
        input logic [1:0] s,
        input logic       b,
        input int         c,
        input string      nm
    );
        exp_t e;
        @(negedge clk);
        reset = r;
        req   = rq;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        e.cnt  = 8'(c);
        q.push_back(e);
        nq.push_back(nm);
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                a.gnt  = gnt;
                a.sel  = {s1, s2};
                a.busy = busy;
                a.cnt  = dut.cnt;
                total++;
                if (a === e) begin
                    passed++;
                end else begin
                    failed++;
                    $display("FAIL %s: got gnt=%b sel=%b busy=%b cnt=%0d want gnt=%b sel=%b busy=%b cnt=%0d",
                             nm, a.gnt, a.sel, a.busy, a.cnt,
                             e.gnt, e.sel, e.busy, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [1:0] idx;
        total  = 0;
        passed = 0;
        failed = 0;
        reset  = 1'b1;
        req    = 4'b0000;

        step(1, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset0");
        step(1, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset1");

        // Single request, then drop: select lines hold 10
        step(0, 4'b0100, 4'b0100, 2'b10, 1, 1, "single_grant");
        step(0, 4'b0100, 4'b0100, 2'b10, 1, 2, "single_hold");
        step(0, 4'b0000, 4'b0000, 2'b10, 0, 0, "single_drop");
        step(0, 4'b0000, 4'b0000, 2'b10, 0, 0, "single_idle");

        // Round robin from reset, each grant 8 cycles
        step(1, 4'b0000, 4'b0000, 2'b00, 0, 0, "rr_reset");
        for (int i = 0; i < 40; i++) begin
            idx = 2'((i / 8) % 4);
            step(0, 4'b1111, 4'b0001 << idx, idx, 1, (i % 8) + 1,
                 $sformatf("rr_%0d", i));
        end

        // Holder 0 at timeout; req=1011 grants 1 for 3 cycles
        step(0, 4'b1011, 4'b0010, 2'b01, 1, 1, "early_g1");
        step(0, 4'b1011, 4'b0010, 2'b01, 1, 2, "early_h1a");
        step(0, 4'b1011, 4'b0010, 2'b01, 1, 3, "early_h1b");
        step(0, 4'b1001, 4'b1000, 2'b11, 1, 1, "early_to3");
        step(0, 4'b0001, 4'b0001, 2'b00, 1, 1, "early_to0");

        // Sole requester regranted on every timeout
        for (int j = 0; j < 20; j++) begin
            step(0, 4'b0001, 4'b0001, 2'b00, 1, ((j + 1) % 8) + 1,
                 $sformatf("sole_%0d", j));
        end

        // Grant on 2 up to cnt=4, then reset with all requesting
        step(0, 4'b0100, 4'b0100, 2'b10, 1, 1, "mid_g2");
        step(0, 4'b0100, 4'b0100, 2'b10, 1, 2, "mid_c2");
        step(0, 4'b0100, 4'b0100, 2'b10, 1, 3, "mid_c3");
        step(0, 4'b0100, 4'b0100, 2'b10, 1, 4, "mid_c4");
        step(1, 4'b1111, 4'b0000, 2'b00, 0, 0, "mid_reset");
        step(0, 4'b1111, 4'b0001, 2'b00, 1, 1, "mid_first0");

        // Holder 3 drops as req[1] rises
        step(0, 4'b1000, 4'b1000, 2'b11, 1, 1, "sim_g3");
        step(0, 4'b0010, 4'b0010, 2'b01, 1, 1, "sim_to1");
        step(0, 4'b0000, 4'b0000, 2'b01, 0, 0, "sim_idle");

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            failed++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
